mem_lsu: RTL and testbench

- Load/store unit directly downstream of the MIPS datapath.
- Consumes aluout (address), writedata and controller load/store controls, runs a handshaked transaction on a word-wide data-memory bus, and returns sign- or zero-extended readdata to the datapath's result mux.
- Raises stall while a transaction is in flight; the datapath holds PC and register writes while stall is high.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_lane.sv | 51 +++++
 rtl/mem_lsu.sv | 147 ++++++++++++++
 tb/tb_mem_lsu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-enable constant.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: byte enables, store-data replication, alignment check,
// and load-data extraction with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  input  logic [1:0]  i_rd_size,
  input  logic [1:0]  i_rd_off,
  input  logic        i_rd_uns,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be       = BE_ALL;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      default: o_misalign = |i_addr_lo;
    endcase
  end

  assign w_byte = i_rdata[{i_rd_off, 3'b000} +: 8];
  assign w_half = i_rd_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_rd_size)
      SZ_BYTE: o_rdata = {{24{~i_rd_uns & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{~i_rd_uns & w_half[15]}}, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the MIPS datapath and a handshaked word-wide data bus.
// Define LSU_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES cycles without bus_ready.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  lsu_state_e  r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_uns;

  logic        w_req;
  logic        w_idle;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic        w_tmo;

  lsu_lane u_lane (
    .i_size     (size),
    .i_addr_lo  (addr[1:0]),
    .i_wdata    (wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_mis),
    .i_rd_size  (r_size),
    .i_rd_off   (r_off),
    .i_rd_uns   (r_uns),
    .i_rdata    (bus_rdata),
    .o_rdata    (w_ext)
  );

  assign w_req  = memread | memwrite;
  assign w_idle = (r_state == ST_IDLE);

  assign misalign  = w_idle & w_req & w_mis;
  assign stall     = (w_idle & w_req & ~w_mis) | (r_state == ST_REQ);
  assign rdata     = misalign ? 32'h0 : r_rdata;
  assign bus_err_o = r_bus_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

`ifdef LSU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tcnt;

  // Counter idles at zero outside REQ, so it is already clear on REQ entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_tcnt <= '0;
    else if (r_state != ST_REQ)  r_tcnt <= '0;
    else if (!bus_ready)         r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_tmo = (r_tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
      r_size      <= SZ_BYTE;
      r_off       <= '0;
      r_uns       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bus_err <= 1'b0;
          if (w_req && !w_mis) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= memwrite;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_size      <= size;
            r_off       <= addr[1:0];
            r_uns       <= ld_unsigned;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            r_rdata   <= (r_bus_we || bus_err) ? 32'h0 : w_ext;
            r_bus_err <= bus_err;
            r_bus_req <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_tmo) begin
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_bus_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized bench for mem_lsu against a behavioural access model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, ld_unsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign, bus_err_o, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err_o(bus_err_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_misalign(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] d);
    logic [31:0] s;
    s = d >> (8 * (a % 4));
    if (sz == 2'd0) begin
      s = s & 32'hFF;
      if (!uns && s >= 32'h80) s = s | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      s = s & 32'hFFFF;
      if (!uns && s >= 32'h8000) s = s | 32'hFFFF_0000;
    end
    return s;
  endfunction

  // Starts just after a rising edge with the DUT idle; ends the same way.
  task automatic xfer(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int waits,
                      input logic [31:0] brd, input logic berr, input bit tmo);
    logic [31:0] exp_rd;
    memread = rd; memwrite = wr; size = sz; ld_unsigned = uns; addr = a; wdata = wd;
    #1;
    if (m_misalign(sz, a)) begin
      chk("mis_flag", misalign, 1);
      chk("mis_stall", stall, 0);
      chk("mis_rdata", rdata, 0);
      chk("mis_req", bus_req, 0);
      @(posedge clk); #1;
      memread = 0; memwrite = 0;
      chk("mis_req_after", bus_req, 0);
      return;
    end
    chk("idle_stall", stall, 1);
    chk("idle_mis", misalign, 0);
    @(posedge clk); #1;
    memread = 1'($urandom); memwrite = 1'($urandom);
    addr = $urandom; wdata = $urandom; size = 2'($urandom);
    for (int i = 0; i <= waits; i++) begin
      bus_ready = (i == waits) && !tmo;
      bus_rdata = (i == waits) ? brd : $urandom;
      bus_err   = (i == waits) ? berr : 1'($urandom);
      #1;
      chk("req_req", bus_req, 1);
      chk("req_stall", stall, 1);
      chk("req_we", bus_we, wr);
      chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_be", bus_be, m_be(sz, a));
      chk("req_wdata", bus_wdata, m_wdata(sz, wd));
      @(posedge clk); #1;
    end
    bus_ready = 0; bus_err = 0;
    memread = 0; memwrite = 0;
    exp_rd = (wr || berr || tmo) ? 32'h0 : m_rdata(sz, uns, a, brd);
    chk("done_stall", stall, 0);
    chk("done_req", bus_req, 0);
    chk("done_rdata", rdata, exp_rd);
    chk("done_err", bus_err_o, (berr || tmo) ? 1 : 0);
    @(posedge clk); #1;
    chk("post_err", bus_err_o, 0);
    chk("post_rdata", rdata, exp_rd);
    chk("post_stall", stall, 0);
  endtask

  initial begin
    logic        rd, wr, uns, berr;
    logic [1:0]  sz;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_mis", misalign, 0);
    reset = 1;
    @(posedge clk); #1;

    xfer(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
    xfer(1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h8012_3456, 0, 0);
    xfer(1, 0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h8012_3456, 0, 0);
    xfer(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 3, 32'h0, 0, 0);
    xfer(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 32'h0, 0, 0);
    xfer(1, 0, 2'd1, 1, 32'h1FE, 32'h0, 1, 32'hC001_7FFF, 0, 0);
    xfer(1, 1, 2'd3, 0, 32'h44, 32'h1234_5678, 0, 32'hFFFF_FFFF, 0, 0);
    xfer(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 32'h1234_5678, 1, 0);

    // Asynchronous reset in the middle of a wait-stated load
    memread = 1; size = 2'd2; addr = 32'h300;
    @(posedge clk); #1;
    memread = 0;
    chk("arst_pre_req", bus_req, 1);
    #2;
    reset = 0;
    #1;
    chk("arst_req", bus_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_be", bus_be, 0);
    chk("arst_addr", bus_addr, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    xfer(1, 0, 2'd2, 0, 32'h304, 32'h0, 1, 32'hCAFE_F00D, 0, 0);

`ifdef LSU_TIMEOUT_EN
    xfer(1, 0, 2'd2, 0, 32'h80, 32'h0, 3, 32'h5555_5555, 0, 1);
`endif

    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      sz = 2'($urandom);
      uns = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        else if (sz != 2'd0) a = a & 32'hFFFF_FFFC;
      end
      berr = ($urandom_range(0, 7) == 0);
      xfer(rd, wr, sz, uns, a, $urandom, int'($urandom_range(0, 3)), $urandom, berr, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
